// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers B = X - A one bit per clock, LSB first, with
// underflow/overflow flags. Define SERIAL_SUB_SATURATE_EN to saturate B instead of wrapping.
module serial_subtractor #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH:0]   X,
   input  logic [DATA_WIDTH-1:0] A,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] B,
   output logic                  underflow,
   output logic                  overflow
);

   localparam int W  = DATA_WIDTH + 1;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [W-1:0]          x_q, x_d, a_q, a_d;
   logic [DATA_WIDTH-1:0] diff_q, diff_d;
   logic                  borrow_q, borrow_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic                  underflow_q, underflow_d;
   logic                  overflow_q, overflow_d;
   logic                  bit_d, borrow_nxt;

   always_comb begin
      // NOTE: every signal takes its held value first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      x_d         = x_q;
      a_d         = a_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      cnt_d       = cnt_q;
      b_d         = b_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;
      bit_d       = x_q[0] ^ a_q[0] ^ borrow_q;
      borrow_nxt  = (~x_q[0] & a_q[0]) | (~(x_q[0] ^ a_q[0]) & borrow_q);

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d      = X;
               a_d      = {1'b0, A};
               borrow_d = 1'b0;
               cnt_d    = CW'(W);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            x_d      = x_q >> 1;
            a_d      = a_q >> 1;
            borrow_d = borrow_nxt;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               // Last bit is D[DATA_WIDTH]; it only feeds the overflow flag.
               state_d     = DONE;
               underflow_d = borrow_nxt;
               overflow_d  = ~borrow_nxt & bit_d;
               b_d         = diff_q;
`ifdef SERIAL_SUB_SATURATE_EN
               if (borrow_nxt)
                  b_d = '0;
               else if (bit_d)
                  b_d = '1;
`endif
            end else begin
               diff_d = {bit_d, diff_q[DATA_WIDTH-1:1]};
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         a_q         <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         b_q         <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         a_q         <= a_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         b_q         <= b_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign B         = b_q;
   assign underflow = underflow_q;
   assign overflow  = overflow_q;

endmodule
